// File: rtl/rv_issue_ctrl_pkg.sv
// Shared constants, state encoding and ID/EX payload for the issue controller.
package rv_issue_ctrl_pkg;

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] MD_WAIT = 2'd1;
  localparam logic [1:0] HALT    = 2'd2;

  typedef enum logic [1:0] {
    S_RUN     = RUN,
    S_MD_WAIT = MD_WAIT,
    S_HALT    = HALT
  } state_t;

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

  function automatic logic is_ebreak(input logic [31:0] insn);
    return insn == EBREAK_INSN;
  endfunction

  // Fields held in the ID/EX register once an instruction issues.
  typedef struct packed {
    logic [AW-1:0] rd;
    logic          rd_we;
    logic          muldiv;
    logic          ebreak;
  } idex_t;

endpackage

// File: rtl/rv_issue_ctrl_if.sv
// ID/EX boundary bundle: IDU fields, EXU handshake, mul/div sequencing, writeback.
interface rv_issue_ctrl_if;
  import rv_issue_ctrl_pkg::*;

  logic            id_valid;
  logic            id_ready;
  logic [AW-1:0]   id_rs1;
  logic [AW-1:0]   id_rs2;
  logic            id_rs1_use;
  logic            id_rs2_use;
  logic [AW-1:0]   id_rd;
  logic            id_rd_we;
  logic            id_muldiv;
  logic            id_ebreak;
  logic            ex_valid;
  logic            ex_ready;
  logic            md_start;
  logic            md_done;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic            flush;
  logic            halted;
  logic [NREG-1:0] sb_busy;

  // Pipeline environment (IDU/EXU/WB) side.
  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use, id_rd, id_rd_we,
           id_muldiv, id_ebreak, ex_ready, md_done, wb_valid, wb_rd, flush,
    input  id_ready, ex_valid, md_start, halted, sb_busy
  );

  // Issue controller side.
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use, id_rd, id_rd_we,
           id_muldiv, id_ebreak, ex_ready, md_done, wb_valid, wb_rd, flush,
    output id_ready, ex_valid, md_start, halted, sb_busy
  );

endinterface

// File: rtl/rv_scoreboard.sv
// Register busy bits: one set port, two clear ports (set wins), two source reads and an rd probe.
module rv_scoreboard
  import rv_issue_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_set_en,
  input  logic [AW-1:0]   i_set_idx,
  input  logic            i_clr_a_en,
  input  logic [AW-1:0]   i_clr_a_idx,
  input  logic            i_clr_b_en,
  input  logic [AW-1:0]   i_clr_b_idx,
  input  logic [AW-1:0]   i_rs1,
  input  logic [AW-1:0]   i_rs2,
  input  logic [AW-1:0]   i_rd,
  output logic            o_rs1_busy,
  output logic            o_rs2_busy,
  output logic            o_rd_busy,
  output logic [NREG-1:0] o_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_next;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_set_en)   w_set[i_set_idx]   = 1'b1;
    if (i_clr_a_en) w_clr[i_clr_a_idx] = 1'b1;
    if (i_clr_b_en) w_clr[i_clr_b_idx] = 1'b1;
    w_next    = (r_busy & ~w_clr) | w_set;
    // x0 is never tracked.
    w_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_next;
  end

  assign o_rs1_busy = r_busy[i_rs1];
  assign o_rs2_busy = r_busy[i_rs2];
  assign o_rd_busy  = r_busy[i_rd];
  assign o_busy     = r_busy;

endmodule

// File: rtl/rv_issue_ctrl.sv
// ID/EX issue controller: RAW/WAW stall via scoreboard, mul/div sequencing, ebreak halt.
// Optional performance counters on perf_cnt when RV_ISSUE_PERF_EN is defined.
module rv_issue_ctrl
  import rv_issue_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  rv_issue_ctrl_if.slave bus
`ifdef RV_ISSUE_PERF_EN
  ,
  output logic [127:0]   perf_cnt
`endif
);

  state_t          r_state;
  idex_t           r_idex;
  logic            r_ex_valid;
  logic            r_md_start;
  logic            r_halted;
  logic            r_md_drop;

  idex_t           w_idex;
  logic            w_rs1_busy;
  logic            w_rs2_busy;
  logic            w_rd_busy;
  logic [NREG-1:0] w_sb;
  logic            w_hazard;
  logic            w_id_ready;
  logic            w_issue;
  logic            w_ex_hs;
  logic            w_set_en;
  logic            w_flush_clr;

  assign w_idex = '{rd: bus.id_rd, rd_we: bus.id_rd_we,
                    muldiv: bus.id_muldiv, ebreak: bus.id_ebreak};

  assign w_hazard = (bus.id_rs1_use & w_rs1_busy) |
                    (bus.id_rs2_use & w_rs2_busy) |
                    (bus.id_rd_we   & w_rd_busy);

  // Held ebreak blocks further issue; a pending dropped mul/div result blocks the next mul/div.
  assign w_id_ready = (r_state == S_RUN) & ~w_hazard & ~bus.flush &
                      (~r_ex_valid | bus.ex_ready) &
                      ~(r_ex_valid & r_idex.ebreak) &
                      ~(bus.id_muldiv & r_md_drop);

  assign w_issue  = bus.id_valid & w_id_ready;
  assign w_ex_hs  = r_ex_valid & bus.ex_ready;
  assign w_set_en = w_issue & bus.id_rd_we & (bus.id_rd != '0);

  // Flush releases the held rd only if the instruction never reached the EXU.
  assign w_flush_clr = bus.flush & r_idex.rd_we &
                       ((r_ex_valid & ~bus.ex_ready) | (r_state == S_MD_WAIT));

  rv_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_set_en    (w_set_en),
    .i_set_idx   (bus.id_rd),
    .i_clr_a_en  (bus.wb_valid),
    .i_clr_a_idx (bus.wb_rd),
    .i_clr_b_en  (w_flush_clr),
    .i_clr_b_idx (r_idex.rd),
    .i_rs1       (bus.id_rs1),
    .i_rs2       (bus.id_rs2),
    .i_rd        (bus.id_rd),
    .o_rs1_busy  (w_rs1_busy),
    .o_rs2_busy  (w_rs2_busy),
    .o_rd_busy   (w_rd_busy),
    .o_busy      (w_sb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_idex     <= '0;
      r_ex_valid <= 1'b0;
      r_md_start <= 1'b0;
      r_halted   <= 1'b0;
      r_md_drop  <= 1'b0;
    end else begin
      r_md_start <= 1'b0;
      if (w_ex_hs) r_ex_valid <= 1'b0;
      if (w_issue) begin
        r_idex <= w_idex;
        if (bus.id_muldiv) begin
          r_md_start <= 1'b1;
          r_state    <= S_MD_WAIT;
        end else begin
          r_ex_valid <= 1'b1;
        end
      end
      case (r_state)
        S_RUN: begin
          if (w_ex_hs && r_idex.ebreak) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
        end
        S_MD_WAIT: begin
          if (bus.flush) begin
            r_state   <= S_RUN;
            r_md_drop <= ~bus.md_done;
          end else if (bus.md_done && r_idex.muldiv) begin
            r_ex_valid <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        default: ;
      endcase
      if (bus.flush) r_ex_valid <= 1'b0;
      // The orphaned result of a flushed mul/div retires the drop flag.
      if (r_md_drop && bus.md_done) r_md_drop <= 1'b0;
    end
  end

  assign bus.id_ready = w_id_ready;
  assign bus.ex_valid = r_ex_valid;
  assign bus.md_start = r_md_start;
  assign bus.halted   = r_halted;
  assign bus.sb_busy  = w_sb;

`ifdef RV_ISSUE_PERF_EN
  localparam int unsigned CW = 32;

  logic [CW-1:0] r_cnt_issued;
  logic [CW-1:0] r_cnt_raw;
  logic [CW-1:0] r_cnt_md;
  logic [CW-1:0] r_cnt_ex;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_issued <= '0;
      r_cnt_raw    <= '0;
      r_cnt_md     <= '0;
      r_cnt_ex     <= '0;
    end else begin
      if (w_ex_hs && (r_cnt_issued != '1))
        r_cnt_issued <= r_cnt_issued + CW'(1);
      if (bus.id_valid && w_hazard && (r_cnt_raw != '1))
        r_cnt_raw <= r_cnt_raw + CW'(1);
      if ((r_state == S_MD_WAIT) && (r_cnt_md != '1))
        r_cnt_md <= r_cnt_md + CW'(1);
      if (r_ex_valid && !bus.ex_ready && (r_cnt_ex != '1))
        r_cnt_ex <= r_cnt_ex + CW'(1);
    end
  end

  assign perf_cnt = {r_cnt_issued, r_cnt_raw, r_cnt_md, r_cnt_ex};
`endif

endmodule

// File: tb/tb_rv_issue_ctrl.sv
// Randomized bench for rv_issue_ctrl: a transaction-level pipeline model predicts each
// cycle's outputs into a queue; an independent monitor pops and compares on the falling edge.
module tb_rv_issue_ctrl;
  import rv_issue_ctrl_pkg::*;

  localparam int NCYC = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv_issue_ctrl_if bus();

`ifdef RV_ISSUE_PERF_EN
  logic [127:0] perf_cnt;
`endif

  rv_issue_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef RV_ISSUE_PERF_EN
    ,
    .perf_cnt (perf_cnt)
`endif
  );

  typedef enum {M_RUN, M_MDW, M_HALT} mode_e;
  typedef struct {
    bit [4:0] rd;
    bit       rd_we;
    bit       muldiv;
    bit       ebreak;
  } instr_t;
  typedef struct {
    bit        id_ready;
    bit        ex_valid;
    bit        md_start;
    bit        halted;
    bit [31:0] sb;
    int        cyc;
  } exp_t;
  typedef struct {
    bit [4:0] rd;
    int       due;
  } wb_t;

  int checks = 0;
  int errors = 0;
  exp_t expq[$];

  // Reference model of the ID/EX boundary.
  mode_e  m_mode;
  bit     m_busy[32];
  instr_t m_held;
  bit     m_hv, m_mdstart, m_drop, m_halted;

  // Environment state: IDU holding slot, writeback and mul/div latency.
  wb_t    wbq[$];
  bit     md_pend;
  int     md_due;
  bit     have;
  int     halt_cnt;

  task automatic model_reset();
    m_mode = M_RUN;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_held   = '{default: 0};
    m_hv     = 1'b0;
    m_mdstart= 1'b0;
    m_drop   = 1'b0;
    m_halted = 1'b0;
    wbq.delete();
    md_pend  = 1'b0;
    have     = 1'b0;
    halt_cnt = 0;
  endtask

  function automatic bit busy(input bit [4:0] r);
    return (r != 5'd0) && m_busy[r];
  endfunction

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the predicted vector for the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("id_ready", e.cyc, 32'(bus.id_ready), 32'(e.id_ready));
        chk("ex_valid", e.cyc, 32'(bus.ex_valid), 32'(e.ex_valid));
        chk("md_start", e.cyc, 32'(bus.md_start), 32'(e.md_start));
        chk("halted",   e.cyc, 32'(bus.halted),   32'(e.halted));
        chk("sb_busy",  e.cyc, bus.sb_busy,       e.sb);
      end
    end
  end

  // Driver + model step.
  initial begin
    bit     drv_rst, hazard, rdy, issue, hs, wbv, mdd;
    bit [4:0] wbr;
    mode_e  old_mode;
    instr_t cur;
    bit [4:0] rs1, rs2;
    bit     u1, u2;
    exp_t   e;

    model_reset();
    cur = '{default: 0};
    rs1 = 5'd0; rs2 = 5'd0; u1 = 1'b0; u2 = 1'b0;
    bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rs1_use = 1'b0;
    bus.id_rs2_use = 1'b0; bus.id_rd = '0; bus.id_rd_we = 1'b0; bus.id_muldiv = 1'b0;
    bus.id_ebreak = 1'b0; bus.ex_ready = 1'b0; bus.md_done = 1'b0; bus.wb_valid = 1'b0;
    bus.wb_rd = '0; bus.flush = 1'b0;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      drv_rst = (c < 3) || (m_halted && halt_cnt >= 4) || ($urandom_range(0, 399) == 0);

      if (!have && $urandom_range(0, 9) < 7) begin
        have = 1'b1;
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        u1  = 1'($urandom_range(0, 1));
        u2  = 1'($urandom_range(0, 1));
        cur.rd     = 5'($urandom_range(0, 7));
        cur.ebreak = ($urandom_range(0, 39) == 0);
        cur.muldiv = !cur.ebreak && ($urandom_range(0, 4) == 0);
        cur.rd_we  = !cur.ebreak && ($urandom_range(0, 4) != 0);
      end

      wbv = 1'b0; wbr = 5'd0;
      for (int i = 0; i < wbq.size(); i++) begin
        if (wbq[i].due <= c) begin
          wbv = 1'b1; wbr = wbq[i].rd; wbq.delete(i);
          break;
        end
      end
      mdd = md_pend ? (c == md_due) : ($urandom_range(0, 19) == 0);

      rst            = drv_rst;
      bus.id_valid   = have && !drv_rst;
      bus.id_rs1     = rs1;
      bus.id_rs2     = rs2;
      bus.id_rs1_use = u1;
      bus.id_rs2_use = u2;
      bus.id_rd      = cur.rd;
      bus.id_rd_we   = cur.rd_we;
      bus.id_muldiv  = cur.muldiv;
      bus.id_ebreak  = cur.ebreak;
      bus.ex_ready   = ($urandom_range(0, 9) < 7);
      bus.flush      = ($urandom_range(0, 11) == 0);
      bus.md_done    = mdd;
      bus.wb_valid   = wbv;
      bus.wb_rd      = wbr;

      hazard = (u1 && busy(rs1)) || (u2 && busy(rs2)) || (cur.rd_we && busy(cur.rd));
      rdy = (m_mode == M_RUN) && !hazard && !bus.flush && (!m_hv || bus.ex_ready) &&
            !(m_hv && m_held.ebreak) && !(cur.muldiv && m_drop);

      e.id_ready = rdy;
      e.ex_valid = m_hv;
      e.md_start = m_mdstart;
      e.halted   = m_halted;
      for (int i = 0; i < 32; i++) e.sb[i] = m_busy[i];
      e.cyc = c;
      expq.push_back(e);

      if (drv_rst) begin
        model_reset();
      end else begin
        issue    = bus.id_valid && rdy;
        hs       = m_hv && bus.ex_ready;
        old_mode = m_mode;
        if (wbv && wbr != 5'd0) m_busy[wbr] = 1'b0;
        if (bus.flush && m_held.rd_we && ((m_hv && !bus.ex_ready) || old_mode == M_MDW))
          m_busy[m_held.rd] = 1'b0;
        if (issue && cur.rd_we && cur.rd != 5'd0) m_busy[cur.rd] = 1'b1;
        if (mdd) md_pend = 1'b0;
        m_mdstart = 1'b0;
        if (hs) begin
          m_hv = 1'b0;
          if (m_held.rd_we) wbq.push_back('{m_held.rd, c + int'($urandom_range(1, 4))});
          if (m_held.ebreak) begin
            m_mode   = M_HALT;
            m_halted = 1'b1;
          end
        end
        if (old_mode == M_MDW) begin
          if (bus.flush) begin
            m_mode = M_RUN;
            m_drop = !mdd;
          end else if (mdd) begin
            m_hv   = 1'b1;
            m_mode = M_RUN;
          end
        end else if (m_drop && mdd) begin
          m_drop = 1'b0;
        end
        if (issue) begin
          have   = 1'b0;
          m_held = cur;
          if (cur.muldiv) begin
            m_mdstart = 1'b1;
            m_mode    = M_MDW;
            md_pend   = 1'b1;
            md_due    = c + int'($urandom_range(2, 7));
          end else begin
            m_hv = 1'b1;
          end
        end
        if (bus.flush) m_hv = 1'b0;
        if (m_halted) halt_cnt++;
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("expq_drained", NCYC, 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
